// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: dmem request/grant/response bus, load alignment, writeback pulse
//
// Purpose:
//   Uses the execute-stage ALU result as the effective address. Issues byte, half
//   or word accesses on a request/grant/response data bus, then aligns and
//   sign/zero-extends load data. Non-memory instructions pass straight through.
//   Each instruction produces exactly one single-cycle writeback record.
//
// Optional feature:
//   LSU_TIMEOUT_EN - bus watchdog. If REQ or WAIT lasts TIMEOUT_CYCLES cycles,
//                    the access is abandoned and reported with exception cause 11.
//
// Ports:
//   clk_i, rst_i              clock; asynchronous active-high reset
//   valid_i / ready_o         instruction handshake from execute (ready_o=1 only in IDLE)
//   is_load_i, is_store_i     memory op kind
//   funct3_i                  access width/signedness (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   alu_result_i              effective address, or result for non-memory ops
//   store_data_i, rd_i        rs2 value and destination register
//   dmem_req_o .. dmem_be_o   bus request: word address, lane-replicated data, byte enables
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i   bus grant and read response
//   wb_valid_o .. wb_data_o   writeback pulse to the register file
//   exc_o, exc_cause_o        exception pulse (01 load misaligned, 10 store misaligned, 11 timeout)

module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [4:0]      rd_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_be_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            exc_o,
    output logic [1:0]      exc_cause_o
);

    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("load_store_unit: XLEN must be 32 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_be;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;

    logic              r_wb_valid;
    logic              r_wb_we;
    logic [4:0]        r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_exc;
    logic [1:0]        r_cause;

    // Accept-time decode. funct3[1] selects word (so 011/110/111 behave as W),
    // otherwise funct3[0] selects half; funct3[2] marks unsigned loads.
    logic              w_is_word;
    logic              w_is_half;
    logic              w_misaligned;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;

    always_comb begin
        w_is_word    = funct3_i[1];
        w_is_half    = !funct3_i[1] && funct3_i[0];
        w_misaligned = 1'b0;
        w_be         = 4'b0001 << alu_result_i[1:0];
        w_wdata      = {4{store_data_i[7:0]}};
        if (w_is_word) begin
            w_misaligned = (alu_result_i[1:0] != 2'b00);
            w_be         = 4'b1111;
            w_wdata      = store_data_i;
        end else if (w_is_half) begin
            w_misaligned = alu_result_i[0];
            w_be         = 4'b0011 << {alu_result_i[1], 1'b0};
            w_wdata      = {2{store_data_i[15:0]}};
        end
    end

    // Load extraction from the latched address lane and width.
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [XLEN-1:0]   w_load_data;

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_ld_byte = dmem_rdata_i[7:0];
            2'd1:    w_ld_byte = dmem_rdata_i[15:8];
            2'd2:    w_ld_byte = dmem_rdata_i[23:16];
            default: w_ld_byte = dmem_rdata_i[31:24];
        endcase
        w_ld_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        if (r_funct3[1]) begin
            w_load_data = dmem_rdata_i;
        end else if (r_funct3[0]) begin
            w_load_data = {{16{!r_funct3[2] && w_ld_half[15]}}, w_ld_half};
        end else begin
            w_load_data = {{24{!r_funct3[2] && w_ld_byte[7]}}, w_ld_byte};
        end
    end

    logic w_timeout;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_state != ST_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero in IDLE so the first REQ cycle counts from 0; cleared again
    // on the grant that moves REQ into WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE || (r_state == ST_REQ && dmem_gnt_i)) begin
            r_cnt <= '0;
        end else if (!w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'b0000;
            r_funct3   <= 3'b000;
            r_rd       <= 5'd0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
            r_exc      <= 1'b0;
            r_cause    <= 2'b00;
        end else begin
            // Writeback fields are pulses: zero unless set below this cycle.
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
            r_exc      <= 1'b0;
            r_cause    <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (!is_load_i && !is_store_i) begin
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= (rd_i != 5'd0);
                            r_wb_rd    <= rd_i;
                            r_wb_data  <= alu_result_i;
                        end else if (w_misaligned) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= rd_i;
                            r_wb_data  <= alu_result_i;
                            r_exc      <= 1'b1;
                            r_cause    <= is_load_i ? 2'b01 : 2'b10;
                        end else begin
                            r_addr   <= alu_result_i;
                            r_we     <= is_store_i;
                            r_wdata  <= w_wdata;
                            r_be     <= w_be;
                            r_funct3 <= funct3_i;
                            r_rd     <= rd_i;
                            r_req    <= 1'b1;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_req      <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= r_addr;
                        r_exc      <= 1'b1;
                        r_cause    <= 2'b11;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= (r_rd != 5'd0);
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_load_data;
                        r_state    <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= r_addr;
                        r_exc      <= 1'b1;
                        r_cause    <= 2'b11;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o = (r_state == ST_IDLE);

    // Bus fields are only meaningful while requesting; keep them quiet otherwise.
    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_req && r_we;
    assign dmem_addr_o  = r_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata_o = r_req ? r_wdata : '0;
    assign dmem_be_o    = r_req ? r_be : 4'b0000;

    assign wb_valid_o  = r_wb_valid;
    assign wb_we_o     = r_wb_we;
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign exc_o       = r_exc;
    assign exc_cause_o = r_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural access model

module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_o;
    logic [1:0]  exc_cause_o;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_i(rd_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Access model in bytes: size, lane, mask, replication, extension.
    function automatic void model(input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [31:0] rdata,
                                  output logic [3:0] be, output logic [31:0] wdata,
                                  output logic mis, output logic [31:0] ld);
        int sz;
        int lane;
        longint unsigned mask;
        logic [31:0] v;
        sz   = f3[1] ? 4 : (f3[0] ? 2 : 1);
        lane = int'(addr % 4);
        mis  = (addr % sz) != 0;
        be   = 4'(((1 << sz) - 1) << lane);
        for (int i = 0; i < 4; i++) wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = (rdata >> (8 * lane)) & 32'(mask);
        if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~32'(mask);
        ld = v;
    endfunction

    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input int gd, input int rvd, input logic [31:0] rdata);
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eld;
        logic        mis;
        model(f3, addr, sd, rdata, ebe, ewd, mis, eld);
        check("ready_at_accept", 32'(ready_o), 32'd1);
        valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3;
        alu_result_i = addr; store_data_i = sd; rd_i = rd;
        tick();
        valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        alu_result_i = $urandom; store_data_i = $urandom;
        if (!(ld || st) || mis) begin
            check("direct_req", 32'(dmem_req_o), 32'd0);
            check("direct_wb_valid", 32'(wb_valid_o), 32'd1);
            check("direct_exc", 32'(exc_o), 32'((ld || st) && mis));
            check("direct_cause", 32'(exc_cause_o), (ld || st) ? (ld ? 32'd1 : 32'd2) : 32'd0);
            check("direct_wb_we", 32'(wb_we_o), 32'(!(ld || st) && rd != 5'd0));
            check("direct_wb_rd", 32'(wb_rd_o), 32'(rd));
            check("direct_wb_data", wb_data_o, addr);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                if (i == gd) dmem_gnt_i = 1'b1;
                check("req_high", 32'(dmem_req_o), 32'd1);
                check("req_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
                check("req_we", 32'(dmem_we_o), 32'(st));
                check("req_be", 32'(dmem_be_o), 32'(ebe));
                if (st) check("req_wdata", dmem_wdata_o, ewd);
                check("req_no_wb", 32'(wb_valid_o), 32'd0);
                check("req_not_ready", 32'(ready_o), 32'd0);
                tick();
            end
            dmem_gnt_i = 1'b0;
            if (st) begin
                check("st_req_drop", 32'(dmem_req_o), 32'd0);
                check("st_wb_valid", 32'(wb_valid_o), 32'd1);
                check("st_wb_we", 32'(wb_we_o), 32'd0);
                check("st_exc", 32'(exc_o), 32'd0);
                check("st_wb_rd", 32'(wb_rd_o), 32'(rd));
            end else begin
                for (int i = 0; i <= rvd; i++) begin
                    check("wait_req_low", 32'(dmem_req_o), 32'd0);
                    check("wait_no_wb", 32'(wb_valid_o), 32'd0);
                    if (i == rvd) begin
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i  = rdata;
                    end else begin
                        dmem_rdata_i  = $urandom;
                    end
                    tick();
                end
                dmem_rvalid_i = 1'b0;
                dmem_rdata_i  = $urandom;
                check("ld_wb_valid", 32'(wb_valid_o), 32'd1);
                check("ld_wb_data", wb_data_o, eld);
                check("ld_wb_we", 32'(wb_we_o), 32'(rd != 5'd0));
                check("ld_wb_rd", 32'(wb_rd_o), 32'(rd));
                check("ld_exc", 32'(exc_o), 32'd0);
            end
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [8];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

        rst_i = 1'b1; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        funct3_i = 3'd0; alu_result_i = '0; store_data_i = '0; rd_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_exc", 32'(exc_o), 32'd0);
        check("rst_addr", dmem_addr_o, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("idle_no_wb", 32'(wb_valid_o), 32'd0);

        // Directed cases from the plan; each back-to-back with the previous wb pulse.
        do_txn(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 0, 0, 32'h0);
        do_txn(1'b0, 1'b0, 3'd0, 32'hCAFE_0001, 32'h0, 5'd0, 0, 0, 32'h0);
        do_txn(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd3, 2, 0, 32'h0);
        do_txn(1'b1, 1'b0, 3'd0, 32'h0000_2002, 32'h0, 5'd7, 0, 0, 32'h0080_0000);
        do_txn(1'b1, 1'b0, 3'd4, 32'h0000_2002, 32'h0, 5'd7, 0, 0, 32'h0080_0000);
        do_txn(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0, 5'd9, 0, 0, 32'h0);
        do_txn(1'b0, 1'b1, 3'd1, 32'h0000_3003, 32'h1111_2222, 5'd9, 0, 0, 32'h0);
        do_txn(1'b1, 1'b0, 3'd1, 32'h0000_4002, 32'h0, 5'd0, 1, 2, 32'h8001_7FFF);
        do_txn(1'b1, 1'b0, 3'd5, 32'h0000_4002, 32'h0, 5'd4, 0, 1, 32'h8001_7FFF);
        do_txn(1'b0, 1'b1, 3'd1, 32'h0000_5002, 32'h0000_BEEF, 5'd1, 0, 0, 32'h0);
        do_txn(1'b0, 1'b1, 3'd2, 32'h0000_6000, 32'hDEAD_BEEF, 5'd1, 3, 0, 32'h0);
        tick();
        check("pulse_drops", 32'(wb_valid_o), 32'd0);

        // Reset while REQ: request must drop without waiting for a clock edge.
        valid_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'd2; alu_result_i = 32'h100; rd_i = 5'd6;
        tick();
        valid_i = 1'b0; is_load_i = 1'b0;
        check("pre_rst_req", 32'(dmem_req_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_req", 32'(dmem_req_o), 32'd0);
        check("async_rst_ready", 32'(ready_o), 32'd1);
        tick();
        rst_i = 1'b0;

        // Reset while WAIT: a late rvalid must not produce writeback.
        valid_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'd2; alu_result_i = 32'h200; rd_i = 5'd6;
        tick();
        valid_i = 1'b0; is_load_i = 1'b0; dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check("wait_ready_low", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check("wait_rst_ready", 32'(ready_o), 32'd1);
        check("wait_rst_wb", 32'(wb_valid_o), 32'd0);
        tick();
        rst_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
        tick();
        dmem_rvalid_i = 1'b0;
        check("late_rvalid_no_wb", 32'(wb_valid_o), 32'd0);
        tick();
        check("late_rvalid_no_wb2", 32'(wb_valid_o), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: no grant ever; exception in cycle 5 counting REQ entry as 0.
        valid_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'd2; alu_result_i = 32'h40; rd_i = 5'd2;
        tick();
        valid_i = 1'b0; is_store_i = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            check("to_req_held", 32'(dmem_req_o), 32'd1);
            check("to_no_wb", 32'(wb_valid_o), 32'd0);
            tick();
        end
        check("to_req_drop", 32'(dmem_req_o), 32'd0);
        check("to_wb_valid", 32'(wb_valid_o), 32'd1);
        check("to_exc", 32'(exc_o), 32'd1);
        check("to_cause", 32'(exc_cause_o), 32'd3);
        check("to_wb_we", 32'(wb_we_o), 32'd0);
        check("to_ready", 32'(ready_o), 32'd1);
        tick();
`endif

        // Randomized mix against the model.
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [2:0] f3;
            kind = int'($urandom_range(0, 2));
            f3 = (kind == 1) ? ld_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 2));
            do_txn(kind == 1, kind == 2, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end
        tick();
        check("final_idle", 32'(wb_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
